// File: rtl/pipe_datapath_if.sv
// -----------------------------------------------------------------------------
// pipe_datapath_if
// Groups the issue, handshake and result signals of the three-stage datapath
// into one bundle, so the datapath and whoever drives it share one connection.
//
// Issue side (master -> slave):
//   in_valid  an operation is presented this cycle
//   hold      freeze request from downstream/control
//   rs1, rs2  source register addresses
//   rd        destination register address
//   RegWrite  write the result to rd at writeback
//   ALUsrc    operand 2 select (0 = register rs2, 1 = ImmOp)
//   ALUctrl   ALU operation code
//   ImmOp     immediate operand
// Result side (slave -> master):
//   in_ready  the pipeline accepts an issue this cycle
//   out_valid ALUout/EQ carry a completed operation
//   ALUout    registered result of the completed operation
//   EQ        registered (op1 == op2) of the completed operation
//   a0        committed contents of the mirrored register
// -----------------------------------------------------------------------------
interface pipe_datapath_if #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
);

  logic               in_valid;
  logic               hold;
  logic               in_ready;
  logic [A_WIDTH-1:0] rs1;
  logic [A_WIDTH-1:0] rs2;
  logic [A_WIDTH-1:0] rd;
  logic               RegWrite;
  logic               ALUsrc;
  logic [2:0]         ALUctrl;
  logic [D_WIDTH-1:0] ImmOp;
  logic               out_valid;
  logic [D_WIDTH-1:0] ALUout;
  logic               EQ;
  logic [D_WIDTH-1:0] a0;

  // The driver of operations (testbench or upstream control)
  modport master (
    output in_valid, hold, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp,
    input  in_ready, out_valid, ALUout, EQ, a0
  );

  // The datapath itself
  modport slave (
    input  in_valid, hold, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp,
    output in_ready, out_valid, ALUout, EQ, a0
  );

endinterface

// File: rtl/pipe_datapath.sv
// -----------------------------------------------------------------------------
// pipe_datapath
// Three-stage register-file/ALU pipeline: ISSUE (register read, forwarding,
// operand mux), EX (ALU), WB (output register and register-file write).
// Dependent back-to-back operations never stall; results are forwarded from
// EX (live ALU output) and from WB.
//
// Ports:
//   clk  single clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  pipe_datapath_if.slave carrying issue inputs and result outputs
// -----------------------------------------------------------------------------
module pipe_datapath #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int A0_IDX  = 10
) (
  input  logic           clk,
  input  logic           rst,
  pipe_datapath_if.slave bus
);

  localparam int NREGS = 2 ** A_WIDTH;
  localparam int SH_W  = $clog2(D_WIDTH);
  localparam logic [A_WIDTH-1:0] A0_ADDR = A0_IDX[A_WIDTH-1:0];

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } aluOp_t;

  logic [D_WIDTH-1:0] regs_q [NREGS];

  logic               exValid_q;
  logic               exRegWrite_q;
  logic [A_WIDTH-1:0] exRd_q;
  aluOp_t             exCtrl_q;
  logic [D_WIDTH-1:0] exOp1_q;
  logic [D_WIDTH-1:0] exOp2_q;

  logic               wbValid_q;
  logic               wbRegWrite_q;
  logic [A_WIDTH-1:0] wbRd_q;
  logic [D_WIDTH-1:0] wbResult_q;
  logic               wbEq_q;

  logic [D_WIDTH-1:0] wbResult_d;
  logic               wbEq_d;

  logic               issue;
  logic               advance;
  logic [D_WIDTH-1:0] op1;
  logic [D_WIDTH-1:0] op2Reg;
  logic [D_WIDTH-1:0] op2;

  assign bus.in_ready = !bus.hold && !rst;
  assign issue        = bus.in_valid && bus.in_ready;
  assign advance      = !bus.hold;

  // Operand fetch at ISSUE. Each source starts from the register file, is
  // overridden by a matching write sitting in WB, and then by a matching
  // write in EX (the younger value wins). Register 0 is forced to zero last,
  // so a discarded write to x0 can never leak through the forwarding paths.
  always_comb begin
    op1    = regs_q[bus.rs1];
    op2Reg = regs_q[bus.rs2];
    if (wbValid_q && wbRegWrite_q && (wbRd_q == bus.rs1)) begin
      op1 = wbResult_q;
    end
    if (wbValid_q && wbRegWrite_q && (wbRd_q == bus.rs2)) begin
      op2Reg = wbResult_q;
    end
    if (exValid_q && exRegWrite_q && (exRd_q == bus.rs1)) begin
      op1 = wbResult_d;
    end
    if (exValid_q && exRegWrite_q && (exRd_q == bus.rs2)) begin
      op2Reg = wbResult_d;
    end
    if (bus.rs1 == '0) begin
      op1 = '0;
    end
    if (bus.rs2 == '0) begin
      op2Reg = '0;
    end
    op2 = bus.ALUsrc ? bus.ImmOp : op2Reg;
  end

  // EX stage ALU. The result doubles as the WB next-state and as the live
  // forwarding value for the operation currently being issued. Shifts use
  // only the low log2(D_WIDTH) bits of operand 2; SLT is a signed compare.
  always_comb begin
    wbResult_d = '0;
    wbEq_d     = (exOp1_q == exOp2_q);
    case (exCtrl_q)
      ALU_ADD: wbResult_d = exOp1_q + exOp2_q;
      ALU_SUB: wbResult_d = exOp1_q - exOp2_q;
      ALU_AND: wbResult_d = exOp1_q & exOp2_q;
      ALU_OR:  wbResult_d = exOp1_q | exOp2_q;
      ALU_XOR: wbResult_d = exOp1_q ^ exOp2_q;
      ALU_SLL: wbResult_d = exOp1_q << exOp2_q[SH_W-1:0];
      ALU_SRL: wbResult_d = exOp1_q >> exOp2_q[SH_W-1:0];
      ALU_SLT: wbResult_d = {{(D_WIDTH-1){1'b0}},
                             ($signed(exOp1_q) < $signed(exOp2_q))};
      default: wbResult_d = '0;
    endcase
  end

  // EX pipeline register. Hold freezes it entirely; otherwise it takes the
  // newly issued operation, or becomes a bubble when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_q    <= 1'b0;
      exRegWrite_q <= 1'b0;
      exRd_q       <= '0;
      exCtrl_q     <= ALU_ADD;
      exOp1_q      <= '0;
      exOp2_q      <= '0;
    end else if (advance) begin
      exValid_q <= issue;
      if (issue) begin
        exRegWrite_q <= bus.RegWrite;
        exRd_q       <= bus.rd;
        exCtrl_q     <= aluOp_t'(bus.ALUctrl);
        exOp1_q      <= op1;
        exOp2_q      <= op2;
      end
    end
  end

  // WB pipeline register, which is also the visible result register. A bubble
  // only clears the valid bit, leaving the last result on ALUout/EQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbValid_q    <= 1'b0;
      wbRegWrite_q <= 1'b0;
      wbRd_q       <= '0;
      wbResult_q   <= '0;
      wbEq_q       <= 1'b0;
    end else if (advance) begin
      wbValid_q <= exValid_q;
      if (exValid_q) begin
        wbRegWrite_q <= exRegWrite_q;
        wbRd_q       <= exRd_q;
        wbResult_q   <= wbResult_d;
        wbEq_q       <= wbEq_d;
      end
    end
  end

  // Register file. The WB entry commits on the edge where it leaves WB, so a
  // held operation writes exactly once, at the first edge after release.
  // Reset wins over any pending write, and x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (advance && wbValid_q && wbRegWrite_q && (wbRd_q != '0)) begin
      regs_q[wbRd_q] <= wbResult_q;
    end
  end

  assign bus.out_valid = wbValid_q;
  assign bus.ALUout    = wbResult_q;
  assign bus.EQ        = wbEq_q;
  assign bus.a0        = regs_q[A0_ADDR];

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
- REQ-001 Parameter A_WIDTH, default 5: register address width; the register file SHALL hold 2**A_WIDTH entries.
- REQ-002 Parameter D_WIDTH, default 32: data width of registers, immediate and ALU result.
- REQ-003 Parameter A0_IDX, default 10: register index SHALL be mirrored on a0.
- REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-005 rst  in  1  reset, synchronous, active-high.
- REQ-006 in_valid  in  1  an operation is presented on the issue inputs this cycle.
- REQ-007 hold  in  1  freeze request from downstream or control.
- REQ-008 in_ready  out  1  the pipeline accepts an issue this cycle.
- REQ-009 rs1, rs2, rd  in  A_WIDTH each  source and destination register addresses.
- REQ-010 RegWrite  in  1  write the result to rd at writeback.
- REQ-011 ALUsrc  in  1  operand 2 select: 0 = register rs2, 1 = ImmOp.
- REQ-012 ALUctrl  in  3  ALU operation code.
- REQ-013 ImmOp  in  D_WIDTH  immediate operand.
- REQ-014 out_valid  out  1  ALUout/EQ carry a completed operation.
- REQ-015 ALUout  out  D_WIDTH  registered result of the completed operation.
- REQ-016 EQ  out  1  registered (op1 == op2) for the completed operation.
- REQ-017 a0  out  D_WIDTH  current committed contents of register A0_IDX.

Function
- REQ-018 Three stages: ISSUE (register read, forwarding, operand mux), EX (ALU), WB (output register, register-file write).
- REQ-019 Issue occurs when in_valid && in_ready; in_ready SHALL equal !hold && !rst.
- REQ-020 Latency: an operation issued at edge N SHALL present out_valid=1 with ALUout/EQ in the cycle after edge N+1; its register write SHALL commit at edge N+2.
- REQ-021 Throughput: one issue per cycle when hold=0; back-to-back issues SHALL produce consecutive out_valid cycles.
- REQ-022 hold=1 freezes EX and WB registers and blocks register-file writes; out_valid/ALUout/EQ SHALL be held, not repeated as new completions.
- REQ-023 ALUctrl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT (signed, result 0 or 1 zero-extended).
- REQ-024 Shift amount SHALL be op2[$clog2(D_WIDTH)-1:0]; ADD/SUB SHALL wrap modulo 2**D_WIDTH with no overflow flag.
- REQ-025 Register 0 SHALL read as zero always; writes to rd=0 SHALL be discarded and never forwarded.
- REQ-026 Forwarding at ISSUE, per source, highest priority first: operation in EX with RegWrite and matching rd (live ALU result); operation in WB with RegWrite and matching rd; register file.
- REQ-027 No stall SHALL ever be required for data hazards; dependent back-to-back operations SHALL see correct values.
- REQ-028 EQ SHALL compare forwarded op1 with the post-mux op2.
- REQ-029 a0 SHALL reflect a write to A0_IDX from the cycle after the commit edge.
- REQ-030 An idle bubble (no issue) SHALL propagate as invalid: no write, out_valid=0.

Reset
- REQ-031 rst=1 at an edge SHALL clear all register-file entries, EX/WB valid bits, out_valid, ALUout, EQ and a0 to zero.
- REQ-032 Operations in flight at reset SHALL be discarded; no register write SHALL occur at a reset edge.
- REQ-033 in_ready SHALL be 0 while rst=1; the first issue is accepted at the first edge with rst=0.

Verification
- REQ-034 After reset: ADD x10 = x0 + imm 5 (ALUsrc=1) -> out_valid two cycles later with ALUout=5, EQ=0; a0=5 the cycle after commit.
- REQ-035 Back-to-back: x1=x0+7, then x2=x1+x1, then x3=x2 SUB x1 -> ALUout 7, 14, 7 on consecutive cycles (EX and WB forwarding).
- REQ-036 Ops: x4=0xF0F0 via imm; XOR with imm 0x00FF -> 0xF00F; SLL by imm 36 (D_WIDTH=32) -> shift 4; SLT 0xFFFFFFFF vs 1 -> 1.
- REQ-037 Write to rd=0 with imm 9, then read x0 with ADD -> result 0, EQ=1 when compared to x0.
- REQ-038 hold asserted 3 cycles mid-stream -> in_ready=0, outputs frozen, no duplicate out_valid; results resume in order after release.
- REQ-039 rst asserted with two operations in flight targeting x10 -> no write commits, a0=0, out_valid=0 next cycle.
